// File: rtl/mul_pipe_hs.sv
// Pipelined WIDTH_A x WIDTH_B multiplier with valid/ready handshake, per-pair
// signed/unsigned mode, and result fitting by saturation or truncation.
module mul_pipe_hs #(
  parameter int WIDTH_A   = 16,
  parameter int WIDTH_B   = 16,
  parameter int WIDTH_MUL = 32,
  parameter int STAGE     = 2,
  parameter int SAT       = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH_A-1:0]   a,
  input  logic [WIDTH_B-1:0]   b,
  input  logic                 signed_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH_MUL-1:0] out,
  output logic                 ovf
);

  localparam int WP = WIDTH_A + WIDTH_B;
  localparam int FW = WP + 1;

  logic                 a_neg;
  logic                 b_neg;
  logic [WIDTH_A-1:0]   mag_a;
  logic [WIDTH_B-1:0]   mag_b;
  logic [WP-1:0]        prod;
  logic                 neg;
  logic [FW-1:0]        full;
  logic [WIDTH_MUL-1:0] fit_res;
  logic                 fit_ovf;
  logic                 adv;
  logic                 accept;

  logic [STAGE-1:0]                vld_q;
  logic [STAGE-1:0]                ovf_q;
  logic [STAGE-1:0][WIDTH_MUL-1:0] res_q;

  // Sign-magnitude multiply; the most-negative operand keeps its full magnitude.
  always_comb begin
    a_neg = signed_mode & a[WIDTH_A-1];
    b_neg = signed_mode & b[WIDTH_B-1];
    mag_a = a_neg ? (WIDTH_A'(0) - a) : a;
    mag_b = b_neg ? (WIDTH_B'(0) - b) : b;
    prod  = WP'(mag_a) * WP'(mag_b);
    neg   = (a_neg ^ b_neg) && (prod != '0);
    full  = neg ? (FW'(0) - {1'b0, prod}) : {1'b0, prod};
  end

  generate
    if (WIDTH_MUL >= FW) begin : g_wide
      // Unsigned products are never negative, so sign extension doubles as zero extension.
      assign fit_res = WIDTH_MUL'($signed(full));
      assign fit_ovf = 1'b0;
    end else begin : g_narrow
      localparam logic [WIDTH_MUL-1:0] SMIN = WIDTH_MUL'(1) << (WIDTH_MUL - 1);
      localparam logic [WIDTH_MUL-1:0] SMAX = ~SMIN;

      logic [FW-WIDTH_MUL:0]   hi_s;
      logic [FW-WIDTH_MUL-1:0] hi_u;
      logic                    fits;

      always_comb begin
        hi_s    = full[FW-1:WIDTH_MUL-1];
        hi_u    = full[FW-1:WIDTH_MUL];
        fits    = signed_mode ? ((hi_s == '0) || (hi_s == '1)) : (hi_u == '0);
        fit_ovf = !fits;
        if (fits || (SAT == 0)) begin
          fit_res = full[WIDTH_MUL-1:0];
        end else if (signed_mode && full[FW-1]) begin
          fit_res = SMIN;
        end else if (signed_mode) begin
          fit_res = SMAX;
        end else begin
          fit_res = '1;
        end
      end
    end
  endgenerate

  assign out_valid = vld_q[STAGE-1];
  assign out       = res_q[STAGE-1];
  assign ovf       = ovf_q[STAGE-1];
  assign adv       = out_ready || !out_valid;
  assign in_ready  = adv;
  assign accept    = in_valid && adv;

  // The whole pipe moves in lockstep; empty slots carry zeros so out stays clean.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      ovf_q <= '0;
      res_q <= '0;
    end else if (adv) begin
      vld_q[0] <= accept;
      ovf_q[0] <= accept & fit_ovf;
      res_q[0] <= accept ? fit_res : '0;
      for (int i = 1; i < STAGE; i++) begin
        vld_q[i] <= vld_q[i-1];
        ovf_q[i] <= ovf_q[i-1];
        res_q[i] <= res_q[i-1];
      end
    end
  end

endmodule

// File: tb/tb_mul_pipe_hs.sv
// Bench for mul_pipe_hs: three instances (8x8->16 truncating, 8x8->8 saturating,
// 8x8->8 truncating) share one stimulus stream and one arithmetic scoreboard.
module tb_mul_pipe_hs;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       in_valid;
  logic       out_ready;
  logic       signed_mode;
  logic [7:0] a;
  logic [7:0] b;

  logic        ir16, ir8s, ir8t;
  logic        ov16, ov8s, ov8t;
  logic        of16, of8s, of8t;
  logic [15:0] o16;
  logic [7:0]  o8s, o8t;

  mul_pipe_hs #(.WIDTH_A(8), .WIDTH_B(8), .WIDTH_MUL(16), .STAGE(3), .SAT(0)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir16), .a(a), .b(b),
    .signed_mode(signed_mode), .out_valid(ov16), .out_ready(out_ready), .out(o16), .ovf(of16));

  mul_pipe_hs #(.WIDTH_A(8), .WIDTH_B(8), .WIDTH_MUL(8), .STAGE(3), .SAT(1)) dut8s (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir8s), .a(a), .b(b),
    .signed_mode(signed_mode), .out_valid(ov8s), .out_ready(out_ready), .out(o8s), .ovf(of8s));

  mul_pipe_hs #(.WIDTH_A(8), .WIDTH_B(8), .WIDTH_MUL(8), .STAGE(3), .SAT(0)) dut8t (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir8t), .a(a), .b(b),
    .signed_mode(signed_mode), .out_valid(ov8t), .out_ready(out_ready), .out(o8t), .ovf(of8t));

  typedef struct {
    logic [15:0] r16;
    logic        o16;
    logic [7:0]  r8s;
    logic        o8s;
    logic [7:0]  r8t;
    logic        o8t;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  exp_t        ovr;
  bit          use_ovr;
  bit          chk_lat;
  int          cyc;
  int          n_vec;
  int          n_err;
  logic [15:0] held_out;
  logic        held_ovf;

  task automatic check_output(string tag, logic [31:0] obs, logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Exact integer product, then fit into wm bits by range test.
  function automatic logic [16:0] fit(longint p, int wm, logic sm, bit sat);
    longint lo, hi, v;
    logic   o;
    lo = sm ? -(longint'(1) << (wm - 1)) : longint'(0);
    hi = sm ? (longint'(1) << (wm - 1)) - 1 : (longint'(1) << wm) - 1;
    o  = (p < lo) || (p > hi);
    v  = (sat && o) ? ((p < lo) ? lo : hi) : p;
    v  = v & ((longint'(1) << wm) - 1);
    return {o, v[15:0]};
  endfunction

  function automatic exp_t model(logic [7:0] x, logic [7:0] y, logic sm);
    exp_t        e;
    longint      xv, yv, p;
    logic [16:0] f;
    xv = sm ? longint'($signed(x)) : longint'(x);
    yv = sm ? longint'($signed(y)) : longint'(y);
    p  = xv * yv;
    f = fit(p, 16, sm, 1'b0); e.r16 = f[15:0]; e.o16 = f[16];
    f = fit(p, 8, sm, 1'b1);  e.r8s = f[7:0];  e.o8s = f[16];
    f = fit(p, 8, sm, 1'b0);  e.r8t = f[7:0];  e.o8t = f[16];
    e.cyc = 0;
    return e;
  endfunction

  task automatic apply_stimulus(logic v, logic [7:0] x, logic [7:0] y, logic sm, logic ordy);
    in_valid    = v;
    a           = x;
    b           = y;
    signed_mode = sm;
    out_ready   = ordy;
  endtask

  // Sample the handshake late in the cycle, score transfers, then advance one edge.
  task automatic tick();
    exp_t e;
    #3;
    if (ov16 && out_ready) begin
      if (sb.size() == 0) begin
        check_output("spurious_out", 32'(ov16), 32'd0);
      end else begin
        e = sb.pop_front();
        check_output("out16", 32'(o16), 32'(e.r16));
        check_output("ovf16", 32'(of16), 32'(e.o16));
        check_output("out8s", 32'(o8s), 32'(e.r8s));
        check_output("ovf8s", 32'(of8s), 32'(e.o8s));
        check_output("out8t", 32'(o8t), 32'(e.r8t));
        check_output("ovf8t", 32'(of8t), 32'(e.o8t));
        if (chk_lat) check_output("latency", 32'(cyc - e.cyc), 32'd3);
      end
    end
    if (in_valid && ir16) begin
      e     = use_ovr ? ovr : model(a, b, signed_mode);
      e.cyc = cyc;
      sb.push_back(e);
      use_ovr = 1'b0;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drain(string tag);
    apply_stimulus(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    repeat (5) tick();
    check_output(tag, 32'(sb.size()), 32'd0);
  endtask

  task automatic directed(logic [7:0] x, logic [7:0] y, logic sm, logic [15:0] e16,
                          logic [7:0] e8s, logic e8so, logic [7:0] e8t, logic e8to);
    ovr.r16 = e16; ovr.o16 = 1'b0;
    ovr.r8s = e8s; ovr.o8s = e8so;
    ovr.r8t = e8t; ovr.o8t = e8to;
    ovr.cyc = 0;
    use_ovr = 1'b1;
    apply_stimulus(1'b1, x, y, sm, 1'b1);
    #1;
    check_output("empty_ready", 32'(ir16), 32'd1);
    tick();
    drain("directed_drain");
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    n_vec   = 0;
    n_err   = 0;
    cyc     = 0;
    use_ovr = 1'b0;
    chk_lat = 1'b1;
    rst_n   = 1'b0;
    apply_stimulus(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    #2;
    check_output("rst_valid", 32'(ov16), 32'd0);
    check_output("rst_out", 32'(o16), 32'd0);
    check_output("rst_ovf", 32'(of16), 32'd0);
    check_output("rst_ready", 32'(ir16), 32'd1);
    check_output("rst_out8s", 32'(o8s), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    $display("[TB] directed products and fitting");
    directed(8'h80, 8'h80, 1'b1, 16'h4000, 8'h7F, 1'b1, 8'h00, 1'b1);
    directed(8'hFD, 8'h05, 1'b1, 16'hFFF1, 8'hF1, 1'b0, 8'hF1, 1'b0);
    directed(8'hFF, 8'hFF, 1'b0, 16'hFE01, 8'hFF, 1'b1, 8'h01, 1'b1);
    directed(8'd100, 8'd2, 1'b1, 16'h00C8, 8'h7F, 1'b1, 8'hC8, 1'b1);
    directed(8'h9C, 8'd2, 1'b1, 16'hFF38, 8'h80, 1'b1, 8'h38, 1'b1);
    directed(8'd16, 8'd16, 1'b0, 16'h0100, 8'hFF, 1'b1, 8'h00, 1'b1);
    directed(8'hF8, 8'd16, 1'b1, 16'hFF80, 8'h80, 1'b0, 8'h80, 1'b0);
    directed(8'd16, 8'd17, 1'b0, 16'h0110, 8'hFF, 1'b1, 8'h10, 1'b1);

    $display("[TB] back-to-back random stream");
    for (int i = 0; i < 10; i++) begin
      apply_stimulus(1'b1, 8'($urandom), 8'($urandom), 1'($urandom), 1'b1);
      tick();
    end
    drain("stream_drain");

    $display("[TB] backpressure");
    chk_lat = 1'b0;
    for (int i = 0; i < 6; i++) begin
      apply_stimulus(1'b1, 8'($urandom), 8'($urandom), 1'($urandom), 1'b1);
      tick();
    end
    held_out = o16;
    held_ovf = of16;
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(1'b1, 8'($urandom), 8'($urandom), 1'($urandom), 1'b0);
      #1;
      check_output("stall_ready16", 32'(ir16), 32'd0);
      check_output("stall_ready8s", 32'(ir8s), 32'd0);
      check_output("stall_ready8t", 32'(ir8t), 32'd0);
      check_output("stall_valid", 32'(ov16), 32'd1);
      check_output("stall_out", 32'(o16), 32'(held_out));
      check_output("stall_ovf", 32'(of16), 32'(held_ovf));
      tick();
    end
    apply_stimulus(1'b1, 8'($urandom), 8'($urandom), 1'($urandom), 1'b1);
    #1;
    check_output("release_ready", 32'(ir16), 32'd1);
    tick();
    for (int i = 0; i < 24; i++) begin
      apply_stimulus(1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), 1'(i));
      tick();
    end
    drain("toggle_drain");

    $display("[TB] reset mid-operation");
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1'b1, 8'($urandom), 8'($urandom), 1'($urandom), 1'b1);
      tick();
    end
    apply_stimulus(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    check_output("pre_rst_valid", 32'(ov16), 32'd1);
    rst_n = 1'b0;
    #1;
    check_output("midrst_valid", 32'(ov16), 32'd0);
    check_output("midrst_out", 32'(o16), 32'd0);
    check_output("midrst_ovf", 32'(of16), 32'd0);
    check_output("midrst_valid8s", 32'(ov8s), 32'd0);
    sb.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check_output("post_rst_idle", 32'(ov16), 32'd0);
      tick();
    end
    chk_lat = 1'b1;
    apply_stimulus(1'b1, 8'($urandom), 8'($urandom), 1'($urandom), 1'b1);
    tick();
    drain("post_rst_drain");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
